// File: rtl/window_3x3_gen.sv
// window_3x3_gen: raster-order 3x3 sliding window with two line buffers.
// Optional WINDOW_BACKPRESSURE_EN adds windowReady/pixelReady handshake.
module window_3x3_gen #(
    parameter int inputWidth  = 8,
    parameter int imageWidth  = 640,
    parameter int imageHeight = 480
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frameStart,
    input  logic [inputWidth-1:0]     pixelIn,
    input  logic                      pixelValid,
`ifdef WINDOW_BACKPRESSURE_EN
    input  logic                      windowReady,
    output logic                      pixelReady,
`endif
    output logic [inputWidth*9-1:0]   windowOut,
    output logic                      windowValid
);

    localparam int colW = $clog2(imageWidth);
    localparam int rowW = $clog2(imageHeight);
    localparam logic [colW-1:0] lastCol = colW'(imageWidth - 1);
    localparam logic [rowW-1:0] lastRow = rowW'(imageHeight - 1);
    localparam logic [colW-1:0] colOne  = colW'(1);
    localparam logic [rowW-1:0] rowOne  = rowW'(1);

    logic [colW-1:0] col;
    logic [rowW-1:0] row;
    logic [colW-1:0] effCol;
    logic [rowW-1:0] effRow;
    logic            canAccept;
    logic            accept;
    logic            inWindow;

    logic [inputWidth-1:0] lineOld [imageWidth];
    logic [inputWidth-1:0] lineMid [imageWidth];
    logic [8:0][inputWidth-1:0] win;

`ifdef WINDOW_BACKPRESSURE_EN
    assign pixelReady = !windowValid || windowReady;
    assign canAccept  = pixelReady;
`else
    assign canAccept  = 1'b1;
`endif

    assign accept    = pixelValid && canAccept;
    assign windowOut = win;

    // frameStart forces the accepted pixel to the frame origin
    always_comb begin
        effCol   = col;
        effRow   = row;
        if (frameStart) begin
            effCol = '0;
            effRow = '0;
        end
        inWindow = (effRow > rowOne) && (effCol > colOne);
    end

    // raster position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (effCol == lastCol) begin
                col <= '0;
                row <= (effRow == lastRow) ? '0 : effRow + rowOne;
            end else begin
                col <= effCol + colOne;
                row <= effRow;
            end
        end
    end

    // line buffers age one line per write; contents need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            lineOld[effCol] <= lineMid[effCol];
            lineMid[effCol] <= pixelIn;
        end
    end

    // window shift registers and valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win         <= '0;
            windowValid <= 1'b0;
        end else if (accept) begin
            win[0]      <= win[1];
            win[1]      <= win[2];
            win[2]      <= lineOld[effCol];
            win[3]      <= win[4];
            win[4]      <= win[5];
            win[5]      <= lineMid[effCol];
            win[6]      <= win[7];
            win[7]      <= win[8];
            win[8]      <= pixelIn;
            windowValid <= inWindow;
        end else if (canAccept) begin
            windowValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: directed checks of window_3x3_gen on a 4x4 image.
// Backpressure scenario builds only with WINDOW_BACKPRESSURE_EN.
module tb_window_3x3_gen;

    localparam logic [71:0] FIRST_WIN = {
        8'd11, 8'd10, 8'd9, 8'd7, 8'd6,
        8'd5, 8'd3, 8'd2, 8'd1
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frameStart = 1'b0;
    logic [7:0]  pixelIn = '0;
    logic        pixelValid = 1'b0;
    logic [71:0] windowOut;
    logic        windowValid;
`ifdef WINDOW_BACKPRESSURE_EN
    logic        windowReady = 1'b1;
    logic        pixelReady;
`endif

    int compared = 0;
    int failed = 0;
    int pulses = 0;
    logic [71:0] firstWin;

    window_3x3_gen #(
        .inputWidth(8),
        .imageWidth(4),
        .imageHeight(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frameStart(frameStart),
        .pixelIn(pixelIn),
        .pixelValid(pixelValid),
`ifdef WINDOW_BACKPRESSURE_EN
        .windowReady(windowReady),
        .pixelReady(pixelReady),
`endif
        .windowOut(windowOut),
        .windowValid(windowValid)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] expWindow(
        input int base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++)
            w[k*8 +: 8] = 8'(base + (r - 2 + k / 3) * 4
                             + (c - 2 + k % 3));
        return w;
    endfunction

    task automatic sendPixel(input logic [7:0] v, input logic fs,
                             input logic expV, input logic [71:0] expW,
                             input string tag);
        @(negedge clk);
        pixelIn    = v;
        frameStart = fs;
        pixelValid = 1'b1;
        @(posedge clk);
        #1;
        pixelValid = 1'b0;
        frameStart = 1'b0;
        compared++;
        if (windowValid !== expV) begin
            failed++;
            $display("FAIL %s valid px=%0d: got %b want %b",
                     tag, v, windowValid, expV);
        end
        if (expV) begin
            compared++;
            if (windowOut !== expW) begin
                failed++;
                $display("FAIL %s window px=%0d: got %h want %h",
                         tag, v, windowOut, expW);
            end
        end
        if (windowValid === 1'b1) pulses++;
    endtask

    task automatic sendIdle(input string tag);
        @(negedge clk);
        pixelValid = 1'b0;
        @(posedge clk);
        #1;
        compared++;
        if (windowValid !== 1'b0) begin
            failed++;
            $display("FAIL %s idle valid: got %b want 0",
                     tag, windowValid);
        end
    endtask

    task automatic runFrame(input int base, input bit useFs,
                            input bit gaps, input string tag);
        int start;
        int r;
        int c;
        logic ev;
        start = pulses;
        for (int idx = 0; idx < 16; idx++) begin
            r  = idx / 4;
            c  = idx % 4;
            ev = (r >= 2) && (c >= 2);
            sendPixel(8'(base + idx), useFs && (idx == 0), ev,
                      ev ? expWindow(base, r, c) : 72'd0, tag);
            if (ev && (pulses - start == 1) && (r == 2) && (c == 2))
                firstWin = windowOut;
            if (gaps) sendIdle(tag);
        end
        compared++;
        if (pulses - start != 4) begin
            failed++;
            $display("FAIL %s pulse count: got %0d want 4",
                     tag, pulses - start);
        end
    endtask

    task automatic test_reset;
        compared++;
        if (windowValid !== 1'b0 || windowOut !== 72'd0) begin
            failed++;
            $display("FAIL reset state: got %b/%h want 0/0",
                     windowValid, windowOut);
        end
`ifdef WINDOW_BACKPRESSURE_EN
        compared++;
        if (pixelReady !== 1'b1) begin
            failed++;
            $display("FAIL reset pixelReady: got %b want 1",
                     pixelReady);
        end
`endif
    endtask

    task automatic test_stream;
        firstWin = '0;
        runFrame(1, 1'b1, 1'b0, "stream");
        compared++;
        if (firstWin !== FIRST_WIN) begin
            failed++;
            $display("FAIL stream first window: got %h want %h",
                     firstWin, FIRST_WIN);
        end
    endtask

    task automatic test_gaps;
        runFrame(1, 1'b1, 1'b1, "gaps");
    endtask

    task automatic test_reset_midframe;
        for (int idx = 0; idx < 7; idx++)
            sendPixel(8'(idx + 1), idx == 0, 1'b0, 72'd0, "rstmid");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compared++;
        if (windowValid !== 1'b0 || windowOut !== 72'd0) begin
            failed++;
            $display("FAIL rstmid async clear: got %b/%h want 0/0",
                     windowValid, windowOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
        firstWin = '0;
        runFrame(1, 1'b0, 1'b0, "rstmid");
        compared++;
        if (firstWin !== FIRST_WIN) begin
            failed++;
            $display("FAIL rstmid first window: got %h want %h",
                     firstWin, FIRST_WIN);
        end
    endtask

    task automatic test_midframe_start;
        for (int idx = 0; idx < 8; idx++)
            sendPixel(8'(idx + 1), idx == 0, 1'b0, 72'd0, "midfs");
        runFrame(50, 1'b1, 1'b0, "midfs");
    endtask

    task automatic test_back_to_back;
        int start;
        start = pulses;
        runFrame(1, 1'b1, 1'b0, "b2b");
        firstWin = '0;
        runFrame(1, 1'b1, 1'b0, "b2b");
        compared++;
        if (pulses - start != 8) begin
            failed++;
            $display("FAIL b2b total windows: got %0d want 8",
                     pulses - start);
        end
        compared++;
        if (firstWin !== FIRST_WIN) begin
            failed++;
            $display("FAIL b2b second first window: got %h want %h",
                     firstWin, FIRST_WIN);
        end
    endtask

`ifdef WINDOW_BACKPRESSURE_EN
    task automatic test_backpressure;
        int start;
        int r;
        int c;
        logic ev;
        start = pulses;
        for (int idx = 0; idx < 11; idx++) begin
            r  = idx / 4;
            c  = idx % 4;
            ev = (r >= 2) && (c >= 2);
            sendPixel(8'(idx + 1), idx == 0, ev,
                      ev ? expWindow(1, r, c) : 72'd0, "bp");
        end
        @(negedge clk);
        windowReady = 1'b0;
        pixelIn     = 8'd12;
        pixelValid  = 1'b1;
        #1;
        compared++;
        if (pixelReady !== 1'b0) begin
            failed++;
            $display("FAIL bp ready drop: got %b want 0", pixelReady);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            compared++;
            if (pixelReady !== 1'b0 || windowValid !== 1'b1
                || windowOut !== FIRST_WIN) begin
                failed++;
                $display("FAIL bp hold %0d: got %b/%b/%h want 0/1/%h",
                         i, pixelReady, windowValid, windowOut,
                         FIRST_WIN);
            end
        end
        windowReady = 1'b1;
        pixelValid  = 1'b0;
        for (int idx = 11; idx < 16; idx++) begin
            r  = idx / 4;
            c  = idx % 4;
            ev = (r >= 2) && (c >= 2);
            sendPixel(8'(idx + 1), 1'b0, ev,
                      ev ? expWindow(1, r, c) : 72'd0, "bp");
        end
        compared++;
        if (pulses - start != 4) begin
            failed++;
            $display("FAIL bp window count: got %0d want 4",
                     pulses - start);
        end
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_stream;
        test_gaps;
        test_reset_midframe;
        test_midframe_start;
        test_back_to_back;
`ifdef WINDOW_BACKPRESSURE_EN
        test_backpressure;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, failed);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 The block SHALL have parameter inputWidth, default 8, giving the pixel width in bits.
REQ-002 The block SHALL have parameter imageWidth, default 640, giving pixels per line (minimum 3).
REQ-003 The block SHALL have parameter imageHeight, default 480, giving lines per frame (minimum 3).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 frameStart  input  1  marks the first pixel of a frame; sampled only when pixelValid=1.
REQ-007 pixelIn  input  inputWidth  raster-order pixel data.
REQ-008 pixelValid  input  1  pixelIn is valid this cycle.
REQ-009 windowOut  output  inputWidth*9  3x3 window; element i occupies bits [i*inputWidth+inputWidth-1 : i*inputWidth].
REQ-010 windowValid  output  1  windowOut holds a complete in-image window.
REQ-011 windowReady  input  1  downstream accepts the window; present only with WINDOW_BACKPRESSURE_EN.
REQ-012 pixelReady  output  1  block accepts a pixel this cycle; present only with WINDOW_BACKPRESSURE_EN.

Function
REQ-013 Window layout SHALL be row-major: 0,1,2 = oldest line; 3,4,5 = middle line; 6,7,8 = newest line; within a row, lower index = leftmost (older) column; element 4 is the centre.
REQ-014 The block SHALL hold two line buffers of imageWidth x inputWidth entries storing the previous two lines.
REQ-015 Per accepted pixel: column 2 of each window row SHALL load the new pixel / line buffer outputs at the current column, columns 0 and 1 SHALL shift left, and line buffers SHALL be written at the current column.
REQ-016 A pixel SHALL be accepted when pixelValid=1 (and pixelReady=1 with backpressure).
REQ-017 The column counter SHALL count 0..imageWidth-1 per accepted pixel and wrap to 0, incrementing the row counter.
REQ-018 The row counter SHALL count 0..imageHeight-1 and wrap to 0 after the last pixel of the frame.
REQ-019 An accepted pixel with frameStart=1 SHALL be treated as column 0, row 0, irrespective of counter state; line-buffer contents SHALL NOT be cleared.
REQ-020 windowValid SHALL assert one cycle after accepting a pixel at row>=2 and column>=2, and deassert otherwise.
REQ-021 Latency pixel-accept to windowValid/windowOut SHALL be exactly 1 cycle; the window then has the accepted pixel at element 8.
REQ-022 Windows spanning a line wrap (column 0 or 1) SHALL NOT be flagged valid.
REQ-023 Per frame exactly (imageWidth-2)*(imageHeight-2) windows SHALL be flagged valid.
REQ-024 Idle cycles (pixelValid=0) SHALL leave counters, window and line buffers unchanged and deassert windowValid (no backpressure build).

Reset
REQ-025 On rst_n=0 the block SHALL asynchronously clear column and row counters, windowOut (all zero) and windowValid; pixelReady SHALL be 1 after reset.
REQ-026 Line-buffer contents SHALL NOT require reset; output validity is gated solely by the counters.
REQ-027 Reset mid-frame SHALL abandon the frame; the next accepted pixel SHALL be treated as row 0, column 0.

Configuration
REQ-028 Macro WINDOW_BACKPRESSURE_EN SHALL add windowReady and pixelReady.
REQ-029 With WINDOW_BACKPRESSURE_EN: while windowValid=1 and windowReady=0, windowOut/windowValid SHALL hold and pixelReady SHALL be 0; pixelReady = !windowValid || windowReady.
REQ-030 Without WINDOW_BACKPRESSURE_EN: both ports SHALL be absent, every valid pixel SHALL be accepted, and windowValid SHALL be a one-cycle pulse.

Verification (imageWidth=4, imageHeight=4, inputWidth=8)
REQ-031 Stream pixels 1..16 continuously with frameStart on pixel 1 -> exactly 4 windowValid pulses; first pulse the cycle after pixel 11, windowOut = {1,2,3,5,6,7,9,10,11} for elements 0..8.
REQ-032 Same frame with pixelValid low every other cycle -> identical 4 windows, each one cycle after its pixel.
REQ-033 rst_n low after pixel 7, then restart frame 1..16 -> first window after reset still {1,2,3,5,6,7,9,10,11}; no window emitted before it.
REQ-034 frameStart asserted on pixel 9 of a frame (mid-frame) -> counters restart; next window appears only after 11 more accepted pixels.
REQ-035 With WINDOW_BACKPRESSURE_EN, windowReady held low 3 cycles during first window -> windowOut stable, pixelReady=0 for 3 cycles, no pixel lost; all 4 windows delivered in order.
REQ-036 Two back-to-back frames of 16 pixels -> 8 windows total, second frame's first window = {1,2,3,5,6,7,9,10,11} again.
